linebuf_kxk_win_p: RTL and testbench
====================================

# linebuf_kxk_win_p

Streaming K×K window generator for the 2D convolution pipeline. It takes P pixels per beat, keeps K−1 previous image rows in line buffers and emits P complete K×K windows per accepted beat to the MAC array. It generalises the fixed 3×3 window generator to any odd kernel size, and adds a ready/valid handshake with backpressure, frame-height tracking, output coordinates and optional start-of-frame resynchronisation.

## Interface
- WIDTH, 256, image width in pixels; must be a multiple of P.
- HEIGHT, 256, image height in rows.
- BITW, 8, bits per pixel.
- P, 4, lanes (pixels per beat), ≥1.
- K, 3, kernel size; odd, 3..7.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat.
- in_sof  in  1  beat is the first of a frame; used only with the configuration macro.
- in_pix_vec  in  P*BITW  pixels {pix[P-1],…,pix[0]}; lane i is at column col+i.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts the output beat.
- out_win  out  P*K*K*BITW  windows; tap (lane i, row ky, col kx) is at bits [((i*K+ky)*K+kx)*BITW +: BITW].
  - ky=0 is the oldest row (r−K+1); kx=K−1 is column col+i of the current row.
- out_lane_valid  out  P  lane i holds a full in-image window.
- out_row  out  $clog2(HEIGHT)  row r of the emitted beat.
- out_col  out  $clog2(WIDTH)  column of lane 0.
- sof_err  out  1  sticky flag: in_sof arrived mid-frame (macro build only, else 0).

## Operation
- An accept happens when in_valid && in_ready. Only accepts change internal state.
- Counters col (step P) and row:
  - When col = WIDTH−P, col wraps to 0 and row increments.
  - When row = HEIGHT−1 wraps, row goes to 0 (next frame).
- Line buffers: K−1 arrays lb[0..K−2] of WIDTH×BITW; lb[j] holds row r−1−j.
  - On accept, for each lane: lb[0][col+i] ← pix[i] and lb[j][col+i] ← lb[j−1][col+i].
  - Reads and writes of the same beat use the old contents (read-before-write).
- Carriers: per window row, the last K−1 columns of that row seen in earlier beats.
  - They form a shift chain spanning ⌈(K−1)/P⌉ beats when K−1 > P.
  - A window tap with column < col comes from the carriers; otherwise it comes from the current beat or from a line-buffer tap.
  - Carriers are zeroed on every row wrap.
- out_lane_valid[i] = (row ≥ K−1) && (col+i ≥ K−1), computed at the accept.
- Line-buffer memory is not reset. Stale contents can only appear in lanes whose out_lane_valid is 0; those taps are don't-care.

## Timing
- Output stage is one register, skid-free: in_ready = !out_valid || out_ready (combinational from out_ready).
- Latency: the accept at edge t gives out_valid=1 with the matching data after edge t. Throughput is 1 beat/cycle.
- While out_valid && !out_ready: out_win, out_lane_valid, out_row, out_col and out_valid hold stable, and in_ready=0.
- With out_valid=1 and out_ready=1 and no new accept, out_valid drops to 0 on the next edge.
- Simultaneous output drain and input accept in one cycle: new data is loaded and out_valid stays 1.
- Reset values: in_ready=1 once rst_n is high; out_valid=0, out_win=0, out_lane_valid=0, out_row=0, out_col=0, sof_err=0. Internal col=0, row=0, carriers=0.
- Reset mid-frame discards the frame. The first accept after release is treated as row 0, col 0.

## Configuration
- LINEBUF_SOF_RESYNC_EN defined:
  - An accepted beat with in_sof=1 is processed as row 0, col 0, whatever the counter values. Carriers are zeroed before the window is formed.
  - If col≠0 or row≠0 at that moment, sof_err is set and stays set until reset.
- Not defined: in_sof is ignored, framing relies only on the WIDTH/HEIGHT counters, and sof_err is tied to 0.

## Test plan
- WIDTH=16, HEIGHT=8, P=4, K=3, pixel value = row*16+col, out_ready=1, 32 beats streamed.
  - Beat (row 2, col 4), lane 0: out_win taps = {2,3,4 / 18,19,20 / 34,35,36}.
  - out_lane_valid=4'b1111 on that beat, 4'b1100 at row 2 col 0, and 0 for rows 0–1.
- Same stream with K=5 and P=4: at row 4, col 4, lane 1 window top-left tap = 1 and bottom-right tap = 69; out_lane_valid=4'b1111.
- Hold out_ready=0 for 5 cycles mid-row: in_ready=0 and outputs unchanged throughout. After release, no beat is lost or duplicated (the out_col sequence stays continuous).
- 8×16 frame followed immediately by a second frame: out_row wraps 7→0, and out_lane_valid is 0 for rows 0–1 of frame 2.
- Assert rst_n low at row 3, col 8: all outputs read 0 asynchronously (before the next edge), and the next accept reports out_row=0, out_col=0.
- LINEBUF_SOF_RESYNC_EN defined: in_sof at row 2, col 8 → sof_err=1 and that beat reports out_row=0, out_col=0. Without the macro, sof_err stays 0 and out_col=8.

Source files
------------

// File: rtl/linebuf_kxk_win_p_if.sv
// Stream bundle for the KxK window generator: pixel beats in, P windows per beat out.
interface linebuf_kxk_win_p_if #(
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned HEIGHT = 256,
  parameter int unsigned BITW   = 8,
  parameter int unsigned P      = 4,
  parameter int unsigned K      = 3
);
  localparam int unsigned RowW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned ColW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic                     in_valid;
  logic                     in_ready;
  logic                     in_sof;
  logic [P*BITW-1:0]        in_pix_vec;
  logic                     out_valid;
  logic                     out_ready;
  logic [P*K*K*BITW-1:0]    out_win;
  logic [P-1:0]             out_lane_valid;
  logic [RowW-1:0]          out_row;
  logic [ColW-1:0]          out_col;
  logic                     sof_err;

  modport master (
    output in_valid, in_sof, in_pix_vec, out_ready,
    input  in_ready, out_valid, out_win, out_lane_valid, out_row, out_col, sof_err
  );

  modport slave (
    input  in_valid, in_sof, in_pix_vec, out_ready,
    output in_ready, out_valid, out_win, out_lane_valid, out_row, out_col, sof_err
  );
endinterface

// File: rtl/linebuf_kxk_win_p.sv
// Streaming KxK window generator with K-1 line buffers and P lanes per beat.
// Optional start-of-frame resync when LINEBUF_SOF_RESYNC_EN is defined.
module linebuf_kxk_win_p #(
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned HEIGHT = 256,
  parameter int unsigned BITW   = 8,
  parameter int unsigned P      = 4,
  parameter int unsigned K      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  linebuf_kxk_win_p_if.slave bus
);
  localparam int unsigned RowW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned ColW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned Depth = WIDTH / P;
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned NumLb = K - 1;
  localparam int unsigned ExtW  = K - 1 + P;

  logic [RowW-1:0] row_q, row_d, row_eff;
  logic [ColW-1:0] col_q, col_d, col_eff;
  logic [K-1:0][K-2:0][BITW-1:0] carry_q, carry_d;
  logic                                   out_valid_q, out_valid_d;
  logic [P-1:0][K-1:0][K-1:0][BITW-1:0]   win_q, win_d;
  logic [P-1:0]                           lv_q, lv_d;
  logic [RowW-1:0]                        out_row_q, out_row_d;
  logic [ColW-1:0]                        out_col_q, out_col_d;

  logic                               accept, sof_hit, wrap;
  logic [AddrW-1:0]                   addr;
  logic [P-1:0][BITW-1:0]             pix;
  logic [NumLb-1:0][P-1:0][BITW-1:0]  lb_rd;
  logic [K-1:0][P-1:0][BITW-1:0]      rows;
  logic [K-1:0][ExtW-1:0][BITW-1:0]   ext;
  logic [P-1:0][BITW-1:0]             lb_mem [NumLb][Depth];

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign pix          = bus.in_pix_vec;
  assign col_eff      = sof_hit ? '0 : col_q;
  assign row_eff      = sof_hit ? '0 : row_q;
  assign wrap         = (col_eff == ColW'(WIDTH - P));
  assign addr         = AddrW'(col_eff / ColW'(P));

  // Line buffers are deliberately unreset; stale taps only reach invalid lanes.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_mem[0][addr] <= pix;
      for (int j = 1; j < NumLb; j++) lb_mem[j][addr] <= lb_mem[j-1][addr];
    end
  end

  always_comb begin
    for (int j = 0; j < NumLb; j++) lb_rd[j] = lb_mem[j][addr];
  end

  // rows[ky]: ky = K-1 is the live beat, lower ky are progressively older rows.
  always_comb begin
    rows      = '0;
    rows[K-1] = pix;
    for (int j = 0; j < NumLb; j++) rows[K-2-j] = lb_rd[j];
  end

  // ext[ky]: K-1 carried columns left of col, then the P columns of this beat.
  always_comb begin
    ext = '0;
    for (int ky = 0; ky < K; ky++) begin
      for (int k = 0; k < K - 1; k++) ext[ky][k] = sof_hit ? '0 : carry_q[ky][k];
      for (int p = 0; p < P; p++) ext[ky][K-1+p] = rows[ky][p];
    end
  end

  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    win_d       = win_q;
    lv_d        = lv_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_row_d   = row_eff;
      out_col_d   = col_eff;
      for (int i = 0; i < P; i++) begin
        lv_d[i] = (int'(row_eff) >= int'(K) - 1) && (int'(col_eff) + i >= int'(K) - 1);
        for (int ky = 0; ky < K; ky++) begin
          for (int kx = 0; kx < K; kx++) win_d[i][ky][kx] = ext[ky][i+kx];
        end
      end
      if (wrap) begin
        col_d   = '0;
        carry_d = '0;
        row_d   = (row_eff == RowW'(HEIGHT - 1)) ? '0 : row_eff + RowW'(1);
      end else begin
        col_d = col_eff + ColW'(P);
        row_d = row_eff;
        for (int ky = 0; ky < K; ky++) begin
          for (int k = 0; k < K - 1; k++) carry_d[ky][k] = ext[ky][P+k];
        end
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      col_q       <= '0;
      carry_q     <= '0;
      out_valid_q <= 1'b0;
      win_q       <= '0;
      lv_q        <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      win_q       <= win_d;
      lv_q        <= lv_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_win        = win_q;
  assign bus.out_lane_valid = lv_q;
  assign bus.out_row        = out_row_q;
  assign bus.out_col        = out_col_q;

`ifdef LINEBUF_SOF_RESYNC_EN
  logic sof_err_q, sof_err_d;

  assign sof_hit = accept && bus.in_sof;

  always_comb begin
    sof_err_d = sof_err_q;
    if (sof_hit && (col_q != '0 || row_q != '0)) sof_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sof_err_q <= 1'b0;
    else        sof_err_q <= sof_err_d;
  end

  assign bus.sof_err = sof_err_q;
`else
  assign sof_hit     = 1'b0;
  assign bus.sof_err = 1'b0;
`endif
endmodule

// File: tb/tb_linebuf_kxk_win_p.sv
// Randomized bench: K=3 and K=5 instances in lockstep, checked against an image-array model.
module tb_linebuf_kxk_win_p;
  localparam int unsigned W  = 16;
  localparam int unsigned H  = 8;
  localparam int unsigned BW = 8;
  localparam int unsigned P  = 4;
  localparam int unsigned WA = P * 3 * 3 * BW;
  localparam int unsigned WB = P * 5 * 5 * BW;
  localparam int unsigned RW = $clog2(H);
  localparam int unsigned CW = $clog2(W);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, in_sof, out_ready;
  logic [P*BW-1:0] pix;

  linebuf_kxk_win_p_if #(.WIDTH(W), .HEIGHT(H), .BITW(BW), .P(P), .K(3)) bus3 ();
  linebuf_kxk_win_p_if #(.WIDTH(W), .HEIGHT(H), .BITW(BW), .P(P), .K(5)) bus5 ();

  assign bus3.in_valid   = in_valid;
  assign bus3.in_sof     = in_sof;
  assign bus3.in_pix_vec = pix;
  assign bus3.out_ready  = out_ready;
  assign bus5.in_valid   = in_valid;
  assign bus5.in_sof     = in_sof;
  assign bus5.in_pix_vec = pix;
  assign bus5.out_ready  = out_ready;

  linebuf_kxk_win_p #(.WIDTH(W), .HEIGHT(H), .BITW(BW), .P(P), .K(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );
  linebuf_kxk_win_p #(.WIDTH(W), .HEIGHT(H), .BITW(BW), .P(P), .K(5)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  typedef struct packed {
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [P-1:0]  lv3;
    logic [P-1:0]  lv5;
    logic          chk3;
    logic          chk5;
    logic          pat;
    logic [WA-1:0] w3;
    logic [WB-1:0] w5;
  } exp_t;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          cyc   = 0;
  int          nacc  = 0;
  int          mrow  = 0;
  int          mcol  = 0;
  bit          msof  = 0;
  bit          pat   = 0;
  logic [BW-1:0] img [H][W];
  exp_t q[$];

  localparam logic [71:0] K3Lane0 =
    {8'd36, 8'd35, 8'd34, 8'd20, 8'd19, 8'd18, 8'd4, 8'd3, 8'd2};

  task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Window straight from the stored image; columns left of the row start read as 0.
  function automatic logic [WB-1:0] exp_win(int k, int r, int c);
    logic [WB-1:0] v;
    v = '0;
    for (int i = 0; i < P; i++)
      for (int ky = 0; ky < k; ky++)
        for (int kx = 0; kx < k; kx++) begin
          int ir, ic;
          ir = r - k + 1 + ky;
          ic = c + i - (k - 1) + kx;
          if (ic >= 0) v[((i * k + ky) * k + kx) * BW +: BW] = img[ir][ic];
        end
    return v;
  endfunction

  task automatic model_accept();
    exp_t e;
    int r, c;
    r = mrow;
    c = mcol;
`ifdef LINEBUF_SOF_RESYNC_EN
    if (in_sof) begin
      if (r != 0 || c != 0) msof = 1;
      r = 0;
      c = 0;
    end
`endif
    for (int p = 0; p < P; p++) img[r][c+p] = pix[p*BW +: BW];
    e      = '0;
    e.row  = RW'(r);
    e.col  = CW'(c);
    e.pat  = pat;
    for (int i = 0; i < P; i++) begin
      e.lv3[i] = (r >= 2) && (c + i >= 2);
      e.lv5[i] = (r >= 4) && (c + i >= 4);
    end
    e.chk3 = (r >= 2);
    e.chk5 = (r >= 4);
    if (e.chk3) e.w3 = WA'(exp_win(3, r, c));
    if (e.chk5) e.w5 = exp_win(5, r, c);
    q.push_back(e);
    c += P;
    if (c == W) begin
      c = 0;
      r = (r == H - 1) ? 0 : r + 1;
    end
    mrow = r;
    mcol = c;
    nacc++;
  endtask

  task automatic set_pix();
    for (int p = 0; p < P; p++)
      pix[p*BW +: BW] = pat ? BW'(mrow * 16 + mcol + p) : BW'($urandom);
  endtask

  task automatic tick();
    exp_t e;
    bit   rdy;
    @(negedge clk);
    cyc++;
    if (cyc > 20000) begin
      $display("FAIL budget: cycles=%0d limit=20000", cyc);
      $fatal(1, "cycle budget exhausted");
    end
    rdy = (q.size() == 0) || out_ready;
    check("in_ready3", bus3.in_ready, rdy);
    check("in_ready5", bus5.in_ready, rdy);
    check("out_valid3", bus3.out_valid, q.size() != 0);
    check("out_valid5", bus5.out_valid, q.size() != 0);
    check("sof_err3", bus3.sof_err, msof);
    check("sof_err5", bus5.sof_err, msof);
    if (q.size() != 0) begin
      e = q[0];
      check("row3", bus3.out_row, e.row);
      check("col3", bus3.out_col, e.col);
      check("row5", bus5.out_row, e.row);
      check("col5", bus5.out_col, e.col);
      check("lv3", bus3.out_lane_valid, e.lv3);
      check("lv5", bus5.out_lane_valid, e.lv5);
      if (e.chk3) check("win3", bus3.out_win, e.w3);
      if (e.chk5) check("win5", bus5.out_win, e.w5);
      if (e.pat && e.row == 2 && e.col == 4) begin
        check("k3_lane0_r2c4", bus3.out_win[71:0], K3Lane0);
        check("lv3_r2c4", bus3.out_lane_valid, 4'b1111);
      end
      if (e.pat && e.row == 2 && e.col == 0) check("lv3_r2c0", bus3.out_lane_valid, 4'b1100);
      if (e.pat && e.row == 4 && e.col == 4) begin
        check("k5_lane1_tl", bus5.out_win[200 +: 8], 8'd1);
        check("k5_lane1_br", bus5.out_win[392 +: 8], 8'd69);
        check("lv5_r4c4", bus5.out_lane_valid, 4'b1111);
      end
    end
    if (q.size() != 0 && out_ready) q.delete(0);
    if (in_valid && rdy) model_accept();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_tick();
    in_valid  = ($urandom_range(0, 3) != 0);
    out_ready = ($urandom_range(0, 4) != 0);
    set_pix();
    tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, bus3.out_valid | bus5.out_valid, 1'b0);
    check({tag, "_win3"}, bus3.out_win, '0);
    check({tag, "_win5"}, bus5.out_win, '0);
    check({tag, "_lv"}, {bus3.out_lane_valid, bus5.out_lane_valid}, '0);
    check({tag, "_row"}, {bus3.out_row, bus5.out_row}, '0);
    check({tag, "_col"}, {bus3.out_col, bus5.out_col}, '0);
    check({tag, "_sof_err"}, {bus3.sof_err, bus5.sof_err}, '0);
  endtask

  initial begin
    int n0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    pix       = '0;
    #12;
    check_zero_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two back-to-back pattern frames with random stalls and one 5-cycle hold.
    pat = 1;
    while (nacc < 64) begin
      if (nacc == 6) begin
        in_valid  = 1'b1;
        out_ready = 1'b1;
        set_pix();
        tick();
        out_ready = 1'b0;
        repeat (5) begin
          set_pix();
          tick();
        end
      end
      rand_tick();
    end

    pat = 0;
    while (nacc < 104) rand_tick();

    // Reset in the middle of a frame with a beat held at the output.
    while (!(mrow == 3 && mcol == 4)) rand_tick();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (mcol != 8) begin
      set_pix();
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    check("midrst_in_ready", bus3.in_ready, 1'b1);
    q.delete();
    mrow = 0;
    mcol = 0;
    msof = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n0 = nacc;
    while (nacc < n0 + 20) rand_tick();

    // Start-of-frame mid-frame at row 2, col 8.
    while (!(mrow == 2 && mcol == 8)) rand_tick();
    in_valid  = 1'b1;
    in_sof    = 1'b1;
    out_ready = 1'b1;
    n0 = nacc;
    while (nacc == n0) begin
      set_pix();
      tick();
    end
    in_sof = 1'b0;
    n0 = nacc;
    while (nacc < n0 + 20) rand_tick();

    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
